ram_dump_reader: RTL

- Bus-master reader that streams RAM contents out of the processor after a halt, replacing the bench-only memory dump with hardware.
- Triggers on a `start` pulse or when the instruction register holds the halt no-op word.
- Requests the RAM address bus from the CPU memory path, reads words START_ADDR..LAST_ADDR sequentially and presents each word with its address on a valid/ready stream.
- Asserts `done` after the last word is accepted.

---
 rtl/ram_dump_reader.sv | 105 ++++++++++
 1 files changed

// File: rtl/ram_dump_reader.sv
// Post-halt RAM dump master: takes the RAM address bus from the CPU, reads
// START_ADDR..LAST_ADDR in order and streams each (addr, word) over valid/ready.
module ram_dump_reader #(
  parameter int              DATA_W     = 32,
  parameter int              ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] START_ADDR = 16'h0000,
  parameter logic [ADDR_W-1:0] LAST_ADDR  = 16'h00FF,
  parameter int              RD_LAT     = 1,
  parameter logic [DATA_W-1:0] HALT_WORD  = 32'h0F000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] instruction,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic              dump_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rw,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic [ADDR_W-1:0] dump_addr,
  output logic              done
);
  localparam int CNT_W = $clog2(RD_LAT + 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_ADDR, S_WAIT, S_SEND, S_DONE} state_t;

  state_t            state, nxt;
  logic [ADDR_W:0]   addr;
  logic [CNT_W-1:0]  cnt;
  logic              prev_halt;
  logic              is_halt, trig, at_last, lat_hit;

  assign is_halt = (instruction == HALT_WORD);
  assign trig    = start | (is_halt & ~prev_halt);
  // Compare ahead of the increment so LAST_ADDR at the top of the range never wraps.
  assign at_last = (addr == {1'b0, LAST_ADDR});
  assign lat_hit = (cnt == CNT_W'(1));
  assign ram_rw  = 1'b0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      addr      <= {1'b0, START_ADDR};
      cnt       <= '0;
      prev_halt <= 1'b0;
      dump_data <= '0;
      dump_addr <= '0;
    end else begin
      state     <= nxt;
      prev_halt <= is_halt;
      case (state)
        S_ADDR: if (bus_gnt) cnt <= CNT_W'(RD_LAT);
        S_WAIT: if (bus_gnt) begin
          cnt <= cnt - CNT_W'(1);
          if (lat_hit) begin
            dump_data <= ram_rdata;
            dump_addr <= addr[ADDR_W-1:0];
          end
        end
        S_SEND: if (dump_ready && !at_last) addr <= addr + (ADDR_W+1)'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    nxt        = state;
    bus_req    = 1'b0;
    dump_en    = 1'b0;
    ram_addr   = '0;
    dump_valid = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: if (trig) nxt = S_REQ;
      S_REQ: begin
        bus_req = 1'b1;
        if (bus_gnt) nxt = S_ADDR;
      end
      S_ADDR, S_WAIT: begin
        bus_req = 1'b1;
        // Release the mux the moment the grant goes; the read restarts from REQ.
        dump_en  = bus_gnt;
        ram_addr = bus_gnt ? addr[ADDR_W-1:0] : '0;
        if (!bus_gnt)                 nxt = S_REQ;
        else if (state == S_ADDR)     nxt = S_WAIT;
        else if (lat_hit)             nxt = S_SEND;
      end
      S_SEND: begin
        bus_req    = 1'b1;
        dump_valid = 1'b1;
        if (dump_ready) begin
          if (at_last)      nxt = S_DONE;
          else if (bus_gnt) nxt = S_ADDR;
          else              nxt = S_REQ;
        end
      end
      S_DONE: done = 1'b1;
      default: nxt = S_IDLE;
    endcase
  end
endmodule
